// File: rtl/anfsqrt_pkg.sv
// Shared definitions for the sqrt/squarer pair: FSM states and the sqrt core query range.
package anfsqrt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned ANFSQRT_QUERY_W = 7;
  localparam int unsigned ANFSQRT_SAT_MAX = 127;

endpackage

// File: rtl/anfsqrt_sqstep.sv
// One shift-add step of the squarer: adds op<<idx to the accumulator when op[idx] is set.
module anfsqrt_sqstep #(
  parameter int unsigned ROOT_W = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic [ROOT_W-1:0]   op,
  input  logic [IDX_W-1:0]    idx,
  input  logic [2*ROOT_W-1:0] acc_in,
  output logic [2*ROOT_W-1:0] acc_out
);

  logic [2*ROOT_W-1:0] pp;

  always_comb begin
    pp      = {{ROOT_W{1'b0}}, op} << idx;
    acc_out = op[idx] ? (acc_in + pp) : acc_in;
  end

endmodule

// File: rtl/anfsqrt_isquare.sv
// Iterative integer squarer, one shift-add per clock, producing queries for the sqrt core.
// Optional ANFSQRT_ISQUARE_SAT7_EN clamps the result to 127 and adds the ovf flag.
module anfsqrt_isquare
  import anfsqrt_pkg::*;
#(
  parameter int unsigned ROOT_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ROOT_W-1:0]   root,
  output logic                busy,
  output logic                done,
`ifdef ANFSQRT_ISQUARE_SAT7_EN
  output logic                ovf,
`endif
  output logic [2*ROOT_W-1:0] square
);

  localparam int unsigned SQ_W  = 2 * ROOT_W;
  localparam int unsigned IDX_W = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;

  state_e            state_q, state_d;
  logic [ROOT_W-1:0] op_q, op_d;
  logic [SQ_W-1:0]   acc_q, acc_d, acc_next;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [SQ_W-1:0]   square_q, square_d;
`ifdef ANFSQRT_ISQUARE_SAT7_EN
  logic              ovf_q, ovf_d;
`endif

  anfsqrt_sqstep #(
    .ROOT_W (ROOT_W),
    .IDX_W  (IDX_W)
  ) u_sqstep (
    .op      (op_q),
    .idx     (idx_q),
    .acc_in  (acc_q),
    .acc_out (acc_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      square_q <= '0;
`ifdef ANFSQRT_ISQUARE_SAT7_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      square_q <= square_d;
`ifdef ANFSQRT_ISQUARE_SAT7_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    square_d = square_q;
`ifdef ANFSQRT_ISQUARE_SAT7_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      ST_RUN: begin
        acc_d  = acc_next;
        idx_d  = idx_q + IDX_W'(1);
        busy_d = 1'b1;
        if (idx_q == IDX_W'(ROOT_W - 1)) begin
          state_d = ST_DONE;
          idx_d   = idx_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef ANFSQRT_ISQUARE_SAT7_EN
          // Clamp to the sqrt core's 7-bit query range.
          if (32'(acc_next) > ANFSQRT_SAT_MAX) begin
            square_d = SQ_W'(ANFSQRT_SAT_MAX);
            ovf_d    = 1'b1;
          end else begin
            square_d = acc_next;
            ovf_d    = 1'b0;
          end
`else
          square_d = acc_next;
`endif
        end
      end
      default: begin
        // IDLE and DONE both accept a new request.
        state_d = ST_IDLE;
        if (start) begin
          state_d = ST_RUN;
          op_d    = root;
          acc_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign square = square_q;
`ifdef ANFSQRT_ISQUARE_SAT7_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_anfsqrt_isquare.sv
// Self-checking bench for anfsqrt_isquare (ROOT_W=4), randomized against an arithmetic model.
module tb_anfsqrt_isquare;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] root;
  logic       busy;
  logic       done;
  logic [7:0] square;
  logic       ovf;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  anfsqrt_isquare #(.ROOT_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .root   (root),
    .busy   (busy),
    .done   (done),
`ifdef ANFSQRT_ISQUARE_SAT7_EN
    .ovf    (ovf),
`endif
    .square (square)
  );

`ifndef ANFSQRT_ISQUARE_SAT7_EN
  assign ovf = 1'b0;
`endif

  function automatic int exp_sq(input int r);
    int s;
    s = r * r;
`ifdef ANFSQRT_ISQUARE_SAT7_EN
    if (s > 127) s = 127;
`endif
    return s;
  endfunction

  function automatic logic exp_ovf(input int r);
`ifdef ANFSQRT_ISQUARE_SAT7_EN
    return (r * r) > 127;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int isqrt(input int v);
    int k;
    k = 0;
    while ((k + 1) * (k + 1) <= v) k++;
    return k;
  endfunction

  // Issue one request and measure latency, busy cycles, overlap and result.
  task automatic do_op(input logic [3:0] r, output int lat, output int busy_n,
                       output int both, output logic [7:0] sq, output logic ov);
    @(negedge clk);
    start = 1'b1;
    root  = r;
    @(negedge clk);
    start = 1'b0;
    root  = 4'($urandom);
    lat = -1; busy_n = 0; both = 0; sq = 8'hxx; ov = 1'bx;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      if (k > 0) @(negedge clk);
      if (busy) busy_n++;
      if (busy && done) both++;
      if (done) begin
        lat = k; sq = square; ov = ovf;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; root = 4'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, ovf, square} !== 11'd0)
      $display("FAIL reset_outputs: got busy=%b done=%b ovf=%b square=%0d, want all 0", busy, done, ovf, square);
    else passes++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, square} !== 10'd0)
      $display("FAIL reset_idle: got busy=%b done=%b square=%0d, want all 0", busy, done, square);
    else passes++;
  endtask

  task automatic test_single(input logic [3:0] r, input string name);
    int lat, bn, both; logic [7:0] sq; logic ov;
    do_op(r, lat, bn, both, sq, ov);
    checks++;
    if (lat !== 4) $display("FAIL %s_latency: got %0d, want 4", name, lat); else passes++;
    checks++;
    if (bn !== 4) $display("FAIL %s_busy_cycles: got %0d, want 4", name, bn); else passes++;
    checks++;
    if (both !== 0) $display("FAIL %s_busy_done_overlap: got %0d, want 0", name, both); else passes++;
    checks++;
    if (sq !== 8'(exp_sq(int'(r))))
      $display("FAIL %s_square: root=%0d got %0d, want %0d", name, r, sq, exp_sq(int'(r)));
    else passes++;
    checks++;
    if (ov !== exp_ovf(int'(r))) $display("FAIL %s_ovf: got %b, want %b", name, ov, exp_ovf(int'(r))); else passes++;
  endtask

  task automatic test_back_to_back;
    int d1 = -1, d2 = -1; logic [7:0] s1 = 8'hxx, s2 = 8'hxx; logic b5 = 1'bx;
    @(negedge clk);
    start = 1'b1; root = 4'd0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) root = 4'd7;
      if (k == 5) begin start = 1'b0; b5 = busy; end
      if (done && d1 < 0) begin d1 = k; s1 = square; end
      else if (done && d2 < 0) begin d2 = k; s2 = square; end
    end
    checks++;
    if (d1 !== 4 || s1 !== 8'd0) $display("FAIL b2b_first: got k=%0d square=%0d, want k=4 square=0", d1, s1); else passes++;
    checks++;
    if (b5 !== 1'b1) $display("FAIL b2b_rearm_busy: got %b, want 1", b5); else passes++;
    checks++;
    if (d2 !== 9 || s2 !== 8'(exp_sq(7)))
      $display("FAIL b2b_second: got k=%0d square=%0d, want k=9 square=%0d", d2, s2, exp_sq(7));
    else passes++;
  endtask

  task automatic test_ignore_start;
    int nd = 0, dk = -1; logic [7:0] sq = 8'hxx;
    @(negedge clk);
    start = 1'b1; root = 4'd3;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (k == 1) begin start = 1'b1; root = 4'd9; end
      if (k == 2) begin start = 1'b0; root = 4'd5; end
      if (done) begin nd++; dk = k; sq = square; end
    end
    checks++;
    if (nd !== 1 || dk !== 4) $display("FAIL ignore_start_dones: got count=%0d k=%0d, want count=1 k=4", nd, dk); else passes++;
    checks++;
    if (sq !== 8'd9) $display("FAIL ignore_start_square: got %0d, want 9", sq); else passes++;
  endtask

  task automatic test_reset_mid;
    int nd = 0, nb = 0; logic [7:0] sq;
    @(negedge clk);
    start = 1'b1; root = 4'd12;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sq = square;
    for (int k = 0; k < 8; k++) begin
      if (done) nd++;
      if (busy) nb++;
      @(negedge clk);
    end
    checks++;
    if (nd !== 0 || nb !== 0) $display("FAIL reset_mid_abort: got dones=%0d busy=%0d, want 0 0", nd, nb); else passes++;
    checks++;
    if (sq !== 8'd0 || square !== 8'd0) $display("FAIL reset_mid_square: got %0d/%0d, want 0", sq, square); else passes++;
    test_single(4'd12, "after_reset");
  endtask

  task automatic test_random;
    int lat, bn, both; logic [7:0] sq; logic ov; logic [3:0] r;
    for (int i = 0; i < 24; i++) begin
      r = 4'($urandom);
      do_op(r, lat, bn, both, sq, ov);
      checks++;
      if (lat !== 4 || bn !== 4 || both !== 0 || sq !== 8'(exp_sq(int'(r))) || ov !== exp_ovf(int'(r)))
        $display("FAIL random_%0d: root=%0d got lat=%0d busy=%0d ovl=%0d sq=%0d ovf=%b, want 4 4 0 %0d %b",
                 i, r, lat, bn, both, sq, ov, exp_sq(int'(r)), exp_ovf(int'(r)));
      else passes++;
      if ($urandom_range(1) == 1) repeat ($urandom_range(3)) @(negedge clk);
    end
  endtask

  task automatic test_roundtrip;
    int lat, bn, both; logic [7:0] sq; logic ov;
    for (int r = 0; r < 12; r++) begin
      do_op(4'(r), lat, bn, both, sq, ov);
      checks++;
      if (lat !== 4 || isqrt(int'(sq)) !== r)
        $display("FAIL roundtrip_%0d: got lat=%0d sqrt(%0d)=%0d, want lat=4 root %0d", r, lat, sq, isqrt(int'(sq)), r);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_single(4'd15, "root15");
    test_single(4'd0, "root0");
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
`ifdef ANFSQRT_ISQUARE_SAT7_EN
    test_single(4'd11, "sat_root11");
    test_single(4'd12, "sat_root12");
    repeat (2) @(negedge clk);
    checks++;
    if (ovf !== 1'b1 || square !== 8'd127) $display("FAIL sat_hold: got ovf=%b square=%0d, want 1 127", ovf, square); else passes++;
`endif
    test_roundtrip();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
